// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, standard or first-word-fall-through
// read mode, and sticky overflow/underflow error flags.
module sync_fifo_param #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [DATA_SIZE-1:0] w_data,
    output logic                 w_full,
    output logic                 w_almost_full,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 r_empty,
    output logic                 r_almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_LVL  = (ADDR_SIZE+1)'(AFULL_THRESH);
    localparam logic [ADDR_SIZE:0] AEMPTY_LVL = (ADDR_SIZE+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_SIZE:0] PTR_ONE    = (ADDR_SIZE+1)'(1);

    // Threshold sanity: an out-of-range threshold would make a flag stuck.
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE:0]   wr_ptr_reg;
    logic [ADDR_SIZE:0]   rd_ptr_reg;
    logic [ADDR_SIZE:0]   count_reg;
    logic [ADDR_SIZE:0]   count_next;
    logic                 overflow_reg;
    logic                 underflow_reg;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 ptr_full;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    // Flags decode only from the registered count, never from w_en/r_en.
    assign w_full         = (count_reg == FULL_COUNT);
    assign r_empty        = (count_reg == '0);
    assign w_almost_full  = (count_reg >= AFULL_LVL);
    assign r_almost_empty = (count_reg <= AEMPTY_LVL);
    assign count          = count_reg;
    assign overflow       = overflow_reg;
    assign underflow      = underflow_reg;

    // Requests are ignored while reset is held so nothing lands in memory.
    assign wr_ok   = w_en && !w_full && !rst;
    assign rd_ok   = r_en && !r_empty && !rst;
    assign wr_addr = wr_ptr_reg[ADDR_SIZE-1:0];
    assign rd_addr = rd_ptr_reg[ADDR_SIZE-1:0];

    // Pointer-based full: same slot, opposite lap.
    assign ptr_full = (wr_ptr_reg[ADDR_SIZE] != rd_ptr_reg[ADDR_SIZE]) &&
                      (wr_addr == rd_addr);

    // Next occupancy: a simultaneous accepted write and read cancel out.
    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + PTR_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - PTR_ONE;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (r_en && r_empty) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= w_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head of the queue is presented directly; valid whenever not empty.
        assign r_data = mem[rd_addr];
    end else begin : g_std
        logic [DATA_SIZE-1:0] r_data_reg;

        // Registered read: data appears the cycle after an accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_reg <= '0;
            end else if (rd_ok) begin
                r_data_reg <= mem[rd_addr];
            end
        end

        assign r_data = r_data_reg;
    end

    // Pointer wrap bookkeeping must always agree with the occupancy counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ptr_full == w_full);
            assert ((wr_ptr_reg - rd_ptr_reg) == count_reg);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read and an FWFT instance
// share one stimulus stream; a small queue model supplies expected data.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;
    logic       err_clr;

    logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
    logic [7:0] s_rdata;
    logic [4:0] s_count;
    logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [4:0] f_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(0),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data),
        .w_full(s_full), .w_almost_full(s_afull),
        .r_en(r_en), .r_data(s_rdata), .r_empty(s_empty),
        .r_almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    sync_fifo_param #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data),
        .w_full(f_full), .w_almost_full(f_afull),
        .r_en(r_en), .r_data(f_rdata), .r_empty(f_empty),
        .r_almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    wire [4:0] s_wp = u_std.wr_ptr_reg;
    wire [4:0] s_rp = u_std.rd_ptr_reg;
    wire       s_ptr_full = (s_wp[4] != s_rp[4]) && (s_wp[3:0] == s_rp[3:0]);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] wd,
                         input logic re, input logic ec);
        w_en    = we;
        w_data  = wd;
        r_en    = re;
        err_clr = ec;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;

        // Reset state
        tick();
        tick();
        check("rst_count", s_count, 0);
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_aempty, 1);
        check("rst_full", s_full, 0);
        check("rst_afull", s_afull, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_unf", s_unf, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_f_empty", f_empty, 1);
        $display("reset released");
        rst = 1'b0;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            q.push_back(8'(i));
            tick();
            check("fill_count", s_count, i + 1);
            check("fill_afull", s_afull, (i + 1 >= 12) ? 1 : 0);
            check("fill_aempty", s_aempty, (i + 1 <= 2) ? 1 : 0);
            check("fill_full", s_full, (i + 1 == 16) ? 1 : 0);
            check("fill_ptr_full", s_ptr_full, (i == 15) ? 1 : 0);
            check("fill_f_count", f_count, i + 1);
            $display("write %02h count %0d", i, s_count);
        end

        // 17th write while full is dropped and flagged
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        check("ovf_flag", s_ovf, 1);
        check("ovf_f_flag", f_ovf, 1);
        check("ovf_count", s_count, 16);
        check("ovf_ptr_full", s_ptr_full, 1);
        $display("overflow write 0xAA count %0d", s_count);

        // Drain: 0xAA must never appear
        for (int i = 0; i < 16; i++) begin
            exp_d = q.pop_front();
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_fwft_head", f_rdata, exp_d);
            tick();
            check("drain_std_data", s_rdata, exp_d);
            check("drain_count", s_count, 15 - i);
            $display("read %02h", s_rdata);
        end
        check("drain_empty", s_empty, 1);
        check("drain_ovf_sticky", s_ovf, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("errclr_ovf", s_ovf, 0);
        check("errclr_unf", s_unf, 0);
        $display("err_clr overflow %0d", s_ovf);

        // Refill, then 20 cycles of simultaneous write and read across wrap
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            q.push_back(8'(i));
            tick();
        end
        check("refill_full", s_full, 1);
        for (int i = 0; i < 20; i++) begin
            exp_d = q.pop_front();
            drive(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
            if (i != 0) q.push_back(8'h40 + 8'(i));
            check("rw_fwft_head", f_rdata, exp_d);
            tick();
            check("rw_std_data", s_rdata, exp_d);
            check("rw_count", s_count, 15);
            $display("rw cycle %0d read %02h count %0d", i, s_rdata, s_count);
        end
        while (q.size() != 0) begin
            exp_d = q.pop_front();
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check("rwd_fwft_head", f_rdata, exp_d);
            tick();
            check("rwd_std_data", s_rdata, exp_d);
            $display("read %02h", s_rdata);
        end
        check("rwd_empty", s_empty, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Underflow on empty read; pointers stay at 51 mod 32 = 19
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("unf_flag", s_unf, 1);
        check("unf_count", s_count, 0);
        check("unf_wp", s_wp, 19);
        check("unf_rp", s_rp, 19);
        $display("underflow read flag %0d", s_unf);

        // FWFT: write into empty shows up right after the write edge
        drive(1'b1, 8'h5C, 1'b0, 1'b0);
        tick();
        check("fwft_empty", f_empty, 0);
        check("fwft_data", f_rdata, 8'h5C);
        $display("fwft write 5C r_data %02h", f_rdata);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("fwft_std_data", s_rdata, 8'h5C);

        // Clear and a new underflow in the same cycle: set wins
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        check("clr_vs_set_unf", s_unf, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("clr_unf", s_unf, 0);
        $display("err_clr underflow %0d", s_unf);

        // Standard read: two writes then back-to-back reads
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("std_rd1", s_rdata, 8'h11);
        tick();
        check("std_rd2", s_rdata, 8'h22);
        check("std_empty", s_empty, 1);
        $display("std reads 11 22 -> %02h", s_rdata);

        // Mid-burst reset with w_en held high
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("pre_rst_unf", s_unf, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        check("burst_count", s_count, 8);
        rst = 1'b1;
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        tick();
        check("mrst_count", s_count, 0);
        check("mrst_empty", s_empty, 1);
        check("mrst_ovf", s_ovf, 0);
        check("mrst_unf", s_unf, 0);
        check("mrst_rdata", s_rdata, 0);
        check("mrst_wp", s_wp, 0);
        check("mrst_rp", s_rp, 0);
        $display("mid-burst reset count %0d", s_count);
        rst = 1'b0;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        check("post_rst_count", s_count, 1);
        check("post_rst_wp", s_wp, 1);
        check("post_rst_fwft", f_rdata, 8'h77);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("post_rst_std", s_rdata, 8'h77);
        $display("post reset read %02h", s_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised synchronous FIFO. It is the same-clock-domain counterpart of async_fifo.
- Adds the following over async_fifo:
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow and underflow error flags
- Used as the buffering stage between producer and consumer logic in one clock domain, and as the reference model partner in FIFO benches.

Parameters:
- DATA_SIZE, 8: width of w_data/r_data in bits.
- ADDR_SIZE, 4: address bits. DEPTH = 2**ADDR_SIZE entries.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, 2**ADDR_SIZE-2: w_almost_full asserts when count >= AFULL_THRESH. Legal range is 1..DEPTH.
- AEMPTY_THRESH, 2: r_almost_empty asserts when count <= AEMPTY_THRESH. Legal range is 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- w_en  in  1  write request.
- w_data  in  DATA_SIZE  write data.
- w_full  out  1  FIFO holds DEPTH entries.
- w_almost_full  out  1  count >= AFULL_THRESH.
- r_en  in  1  read request.
- r_data  out  DATA_SIZE  read data.
- r_empty  out  1  no readable entry.
- r_almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Storage:
  - DEPTH x DATA_SIZE memory.
  - Write and read pointers are ADDR_SIZE+1 bits; the MSB is the wrap bit.
  - Memory contents are not reset.
- Write accept: wr_ok = w_en && !w_full. On wr_ok, mem[wr_ptr] <= w_data and wr_ptr increments.
- Read accept: rd_ok = r_en && !r_empty. On rd_ok, rd_ptr increments.
- Count update: count <= count + wr_ok - rd_ok.
  - When full, a simultaneous write and read gives read accepted, write dropped, count = DEPTH-1.
  - When empty, a simultaneous write and read gives write accepted, read dropped, count = 1.
  - Otherwise a simultaneous write and read leaves count unchanged.
- Flags:
  - w_full = (count == DEPTH); r_empty = (count == 0); almost flags per their thresholds.
  - All flags decode from the registered count only. There is no combinational path from w_en or r_en to any flag.
- Pointer wrap:
  - Pointers wrap modulo 2**(ADDR_SIZE+1).
  - Full is also detectable as equal low address bits with differing MSB. The implementation must agree with count; this is asserted in the bench.
- FWFT=0 (standard read):
  - r_data <= mem[rd_ptr] on rd_ok, so data is valid one cycle after r_en is sampled.
  - r_data holds its value when there is no rd_ok.
- FWFT=1 (first-word-fall-through):
  - r_data = mem[rd_ptr], combinational from the memory head, and is valid whenever r_empty = 0.
  - On rd_ok the next entry appears the following cycle.
  - After a write into an empty FIFO, the data is visible and r_empty drops one cycle after the write edge.
  - While r_empty = 1, r_data is don't-care; the bench must not check it.
- Error flags:
  - overflow <= 1 when w_en && w_full; underflow <= 1 when r_en && r_empty.
  - Both are cleared by rst or err_clr. If err_clr and a new error occur in the same cycle, set wins.
  - Rejected operations change no other state.
- Reset (any cycle, including mid-burst), with effect on the next edge:
  - wr_ptr = rd_ptr = 0, count = 0.
  - r_empty = 1, r_almost_empty = 1, w_full = 0, w_almost_full = 0.
  - overflow = underflow = 0; registered r_data = 0 (FWFT=0 only).
  - w_en and r_en are ignored while rst = 1.
- Parameter checks: elaboration-time assertion on the legal threshold ranges.

Test Plan (DATA_SIZE=8, ADDR_SIZE=4, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=2):
- Reset, then write 0x00..0x0F on 16 consecutive cycles:
  - count steps 1..16.
  - w_almost_full rises on the edge where count reaches 12.
  - w_full = 1 at count 16.
  - r_almost_empty falls at count 3.
- From full, a 17th write of 0xAA:
  - overflow = 1 and count stays 16.
  - Subsequent reads return 0x00..0x0F; 0xAA never appears.
  - err_clr clears overflow.
- From full, 20 cycles of simultaneous write (0x40+i) and read:
  - First cycle: read only, count = 15.
  - Then count holds 15 and the output order stays contiguous across pointer wrap.
- Empty FIFO, r_en for one cycle: underflow = 1, pointers unchanged. Then one write of 0x5C with FWFT=1: r_data = 0x5C and r_empty = 0 one cycle after the write.
- FWFT=0, write 0x11 and 0x22, then read twice back-to-back: r_data = 0x11 one cycle after the first read edge, 0x22 one cycle after the second.
- Write 8 entries, assert rst for one cycle mid-burst (w_en held high): count = 0, r_empty = 1, overflow = 0, and no write is accepted during the rst cycle.
